// File: rtl/dram_cmd_sched.sv
// Per-channel DRAM command sequencer: open-row tracking for 2 ranks x 8 banks, ACT/RD/WR/PRE/PREALL/REF timing.
// Optional close-page (auto-precharge) policy enabled by defining DRAM_CLOSE_PAGE_EN.
module dram_cmd_sched #(
   parameter int TRCD = 3,
   parameter int TRP  = 3,
   parameter int TRAS = 6,
   parameter int TRFC = 12
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic        req_rank,
   input  logic [2:0]  req_bank,
   input  logic [14:0] req_ras,
   input  logic [13:0] req_cas,
   input  logic        req_addr_err,
   output logic        req_ack,
   output logic        err_drop,
   input  logic        ref_req,
   output logic        ref_ack,
   output logic        cmd_valid,
   output logic [2:0]  cmd_type,
   output logic        cmd_rank,
   output logic [2:0]  cmd_bank,
   output logic [14:0] cmd_addr,
   output logic        busy
);

   localparam logic [2:0] C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3;
   localparam logic [2:0] C_PRE = 3'd4, C_PREALL = 3'd5, C_REF = 3'd6;
   localparam logic [5:0] TRCD_M1 = 6'(TRCD - 1);
   localparam logic [5:0] TRP_M1  = 6'(TRP - 1);
   localparam logic [5:0] TRFC_M1 = 6'(TRFC - 1);
   localparam logic [3:0] TRAS_M1 = 4'(TRAS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_ACT, S_CAS, S_REF_PRE, S_REF, S_REF_WAIT
   } state_t;

   state_t      state;
   logic [5:0]  wait_cnt;
   logic [15:0] row_valid;
   logic [14:0] row_addr [16];
   logic [3:0]  tras_cnt [16];

   logic [3:0]  idx;
   logic        hit;
   logic        all_tras_zero;
   logic [14:0] cas_addr;

   assign idx = {req_rank, req_bank};
   assign hit = row_valid[idx] && (row_addr[idx] == req_ras);

`ifdef DRAM_CLOSE_PAGE_EN
   logic [5:0] cp_wait;
   assign cas_addr = {1'b0, req_cas} | 15'h0400;
   // Bank may not be reopened before both its auto-precharge and its tRAS window complete.
   assign cp_wait  = ({2'b00, tras_cnt[idx]} > 6'(TRP)) ? ({2'b00, tras_cnt[idx]} - 6'd1) : TRP_M1;
`else
   assign cas_addr = {1'b0, req_cas} & ~15'h0400;
`endif

   always_comb begin
      all_tras_zero = 1'b1;
      for (int i = 0; i < 16; i++)
         if (tras_cnt[i] != 4'd0) all_tras_zero = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state     <= S_IDLE;
         wait_cnt  <= 6'd0;
         row_valid <= 16'd0;
         for (int i = 0; i < 16; i++) begin
            row_addr[i] <= 15'd0;
            tras_cnt[i] <= 4'd0;
         end
         req_ack   <= 1'b0;
         err_drop  <= 1'b0;
         ref_ack   <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_type  <= 3'd0;
         cmd_rank  <= 1'b0;
         cmd_bank  <= 3'd0;
         cmd_addr  <= 15'd0;
         busy      <= 1'b0;
      end else begin
         req_ack   <= 1'b0;
         err_drop  <= 1'b0;
         ref_ack   <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_type  <= 3'd0;
         cmd_rank  <= 1'b0;
         cmd_bank  <= 3'd0;
         cmd_addr  <= 15'd0;
         if (wait_cnt != 6'd0) wait_cnt <= wait_cnt - 6'd1;
         for (int i = 0; i < 16; i++)
            if (tras_cnt[i] != 4'd0) tras_cnt[i] <= tras_cnt[i] - 4'd1;

         case (state)
            // Arbitration is skipped while an ack is on the wire so a held request is not taken twice.
            S_IDLE: if (wait_cnt == 6'd0 && !req_ack && !ref_ack) begin
               if (ref_req) begin
                  state <= S_REF_PRE;
                  busy  <= 1'b1;
               end else if (req_valid && req_addr_err) begin
                  req_ack  <= 1'b1;
                  err_drop <= 1'b1;
               end else if (req_valid && hit) begin
                  cmd_valid <= 1'b1;
                  cmd_type  <= req_write ? C_WR : C_RD;
                  cmd_rank  <= req_rank;
                  cmd_bank  <= req_bank;
                  cmd_addr  <= cas_addr;
                  req_ack   <= 1'b1;
`ifdef DRAM_CLOSE_PAGE_EN
                  row_valid[idx] <= 1'b0;
                  wait_cnt       <= cp_wait;
`endif
               end else if (req_valid && !row_valid[idx]) begin
                  cmd_valid     <= 1'b1;
                  cmd_type      <= C_ACT;
                  cmd_rank      <= req_rank;
                  cmd_bank      <= req_bank;
                  cmd_addr      <= req_ras;
                  row_valid[idx] <= 1'b1;
                  row_addr[idx]  <= req_ras;
                  tras_cnt[idx]  <= TRAS_M1;
                  wait_cnt      <= TRCD_M1;
                  state         <= S_CAS;
                  busy          <= 1'b1;
               end else if (req_valid && tras_cnt[idx] == 4'd0) begin
                  cmd_valid      <= 1'b1;
                  cmd_type       <= C_PRE;
                  cmd_rank       <= req_rank;
                  cmd_bank       <= req_bank;
                  row_valid[idx] <= 1'b0;
                  wait_cnt       <= TRP_M1;
                  state          <= S_ACT;
                  busy           <= 1'b1;
               end else if (req_valid) begin
                  state <= S_PRE;
                  busy  <= 1'b1;
               end
            end
            S_PRE: if (tras_cnt[idx] == 4'd0) begin
               cmd_valid      <= 1'b1;
               cmd_type       <= C_PRE;
               cmd_rank       <= req_rank;
               cmd_bank       <= req_bank;
               row_valid[idx] <= 1'b0;
               wait_cnt       <= TRP_M1;
               state          <= S_ACT;
            end
            S_ACT: if (wait_cnt == 6'd0) begin
               cmd_valid      <= 1'b1;
               cmd_type       <= C_ACT;
               cmd_rank       <= req_rank;
               cmd_bank       <= req_bank;
               cmd_addr       <= req_ras;
               row_valid[idx] <= 1'b1;
               row_addr[idx]  <= req_ras;
               tras_cnt[idx]  <= TRAS_M1;
               wait_cnt       <= TRCD_M1;
               state          <= S_CAS;
            end
            S_CAS: if (wait_cnt == 6'd0) begin
               cmd_valid <= 1'b1;
               cmd_type  <= req_write ? C_WR : C_RD;
               cmd_rank  <= req_rank;
               cmd_bank  <= req_bank;
               cmd_addr  <= cas_addr;
               req_ack   <= 1'b1;
`ifdef DRAM_CLOSE_PAGE_EN
               row_valid[idx] <= 1'b0;
               wait_cnt       <= cp_wait;
`endif
               state     <= S_IDLE;
               busy      <= 1'b0;
            end
            S_REF_PRE: if (row_valid == 16'd0) begin
               state <= S_REF;
            end else if (all_tras_zero) begin
               cmd_valid <= 1'b1;
               cmd_type  <= C_PREALL;
               cmd_addr  <= 15'h0400;
               row_valid <= 16'd0;
               wait_cnt  <= TRP_M1;
               state     <= S_REF;
            end
            S_REF: if (wait_cnt == 6'd0) begin
               cmd_valid <= 1'b1;
               cmd_type  <= C_REF;
               wait_cnt  <= TRFC_M1;
               state     <= S_REF_WAIT;
            end
            S_REF_WAIT: if (wait_cnt == 6'd0) begin
               ref_ack <= 1'b1;
               state   <= S_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Directed bench for dram_cmd_sched (open-page build): expected command events carry their cycle stamp.
module tb_dram_cmd_sched;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        req_valid, req_write, req_rank, req_addr_err;
   logic [2:0]  req_bank;
   logic [14:0] req_ras;
   logic [13:0] req_cas;
   logic        req_ack, err_drop, ref_req, ref_ack;
   logic        cmd_valid, cmd_rank, busy;
   logic [2:0]  cmd_type, cmd_bank;
   logic [14:0] cmd_addr;

   typedef struct packed {
      logic [15:0] cyc;
      logic        v;
      logic [2:0]  typ;
      logic        rank;
      logic [2:0]  bank;
      logic [14:0] addr;
      logic        ack;
      logic        drop;
      logic        rack;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  base;

   localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3;
   localparam logic [2:0] PRE = 3'd4, PREALL = 3'd5, REFC = 3'd6;

   dram_cmd_sched dut (
      .clk(clk), .rst_l(rst_l),
      .req_valid(req_valid), .req_write(req_write), .req_rank(req_rank),
      .req_bank(req_bank), .req_ras(req_ras), .req_cas(req_cas),
      .req_addr_err(req_addr_err), .req_ack(req_ack), .err_drop(err_drop),
      .ref_req(ref_req), .ref_ack(ref_ack),
      .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_rank(cmd_rank),
      .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .busy(busy)
   );

   // clock / cycle stamp
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_ev(input int c, input logic [2:0] t, input logic r, input logic [2:0] b,
                          input logic [14:0] a, input logic ack, input logic drop, input logic rack);
      ev_t e;
      e.cyc = 16'(c); e.v = (t != NOP); e.typ = t; e.rank = r; e.bank = b;
      e.addr = a; e.ack = ack; e.drop = drop; e.rack = rack;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive_req(input logic w, input logic r, input logic [2:0] b,
                            input logic [14:0] ras, input logic [13:0] cas, input logic err);
      req_write = w; req_rank = r; req_bank = b; req_ras = ras; req_cas = cas;
      req_addr_err = err; req_valid = 1'b1;
   endtask

   task automatic wait_ack(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = req_ack;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL %s: req_ack timeout got 0 want 1", nm);
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_ref(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = ref_ack;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL %s: ref_ack timeout got 0 want 1", nm);
      end
      ref_req = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_l && (cmd_valid || req_ack || ref_ack || err_drop)) begin
         ev_t got;
         got.cyc = 16'(cyc); got.v = cmd_valid; got.typ = cmd_type; got.rank = cmd_rank;
         got.bank = cmd_bank; got.addr = cmd_addr; got.ack = req_ack; got.drop = err_drop;
         got.rack = ref_ack;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %h want none", got);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (got !== e) begin
               bad++;
               $display("FAIL event: got %h want %h", got, e);
            end
         end
      end
   end

   initial begin
      rst_l = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_rank = 1'b0; req_bank = 3'd0;
      req_ras = 15'd0; req_cas = 14'd0; req_addr_err = 1'b0; ref_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_cmd_type", 32'(cmd_type), 32'd0);
      chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
      chk("rst_acks", 32'({req_ack, err_drop, ref_ack}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_l = 1'b1;
      @(negedge clk);

      // closed bank read: ACT then RD after TRCD
      base = cyc;
      drive_req(1'b0, 1'b0, 3'd2, 15'h0123, 14'h0045, 1'b0);
      push_ev(base + 1, ACT, 1'b0, 3'd2, 15'h0123, 1'b0, 1'b0, 1'b0);
      push_ev(base + 4, RD,  1'b0, 3'd2, 15'h0045, 1'b1, 1'b0, 1'b0);
      wait_ack("s1_read");

      // page conflict: PRE held by tRAS, then ACT, then WR with column bit10 cleared
      base = cyc;
      drive_req(1'b1, 1'b0, 3'd2, 15'h0124, 14'h0567, 1'b0);
      push_ev(base + 3, PRE, 1'b0, 3'd2, 15'h0000, 1'b0, 1'b0, 1'b0);
      push_ev(base + 6, ACT, 1'b0, 3'd2, 15'h0124, 1'b0, 1'b0, 1'b0);
      push_ev(base + 9, WR,  1'b0, 3'd2, 15'h0167, 1'b1, 1'b0, 1'b0);
      wait_ack("s3_conflict");

      // page hit: RD only
      base = cyc;
      drive_req(1'b0, 1'b0, 3'd2, 15'h0124, 14'h0012, 1'b0);
      push_ev(base + 2, RD, 1'b0, 3'd2, 15'h0012, 1'b1, 1'b0, 1'b0);
      wait_ack("s2_hit");

      // refresh beats a simultaneous request; table cleared so the old row needs ACT again
      base = cyc;
      ref_req = 1'b1;
      drive_req(1'b0, 1'b0, 3'd2, 15'h0124, 14'h0033, 1'b0);
      push_ev(base + 3,  PREALL, 1'b0, 3'd0, 15'h0400, 1'b0, 1'b0, 1'b0);
      push_ev(base + 6,  REFC,   1'b0, 3'd0, 15'h0000, 1'b0, 1'b0, 1'b0);
      push_ev(base + 18, NOP,    1'b0, 3'd0, 15'h0000, 1'b0, 1'b0, 1'b1);
      push_ev(base + 20, ACT,    1'b0, 3'd2, 15'h0124, 1'b0, 1'b0, 1'b0);
      push_ev(base + 23, RD,     1'b0, 3'd2, 15'h0033, 1'b1, 1'b0, 1'b0);
      wait_ref("s4_ref");
      wait_ack("s4_req");

      // address error: dropped, no command
      base = cyc;
      drive_req(1'b0, 1'b1, 3'd5, 15'h0010, 14'h0020, 1'b1);
      push_ev(base + 2, NOP, 1'b0, 3'd0, 15'h0000, 1'b1, 1'b1, 1'b0);
      wait_ack("s5_err");

      // extreme addresses on rank 1, bank 7
      base = cyc;
      drive_req(1'b0, 1'b1, 3'd7, 15'h7fff, 14'h3fff, 1'b0);
      push_ev(base + 2, ACT, 1'b1, 3'd7, 15'h7fff, 1'b0, 1'b0, 1'b0);
      push_ev(base + 5, RD,  1'b1, 3'd7, 15'h3bff, 1'b1, 1'b0, 1'b0);
      wait_ack("s5b_max");

      // reset between ACT and RD, then the held request starts over
      base = cyc;
      drive_req(1'b0, 1'b0, 3'd3, 15'h0055, 14'h0011, 1'b0);
      push_ev(base + 2, ACT, 1'b0, 3'd3, 15'h0055, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_l = 1'b0;
      #1;
      chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("midrst_cmd_type", 32'(cmd_type), 32'd0);
      chk("midrst_cmd_addr", 32'(cmd_addr), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      base = cyc;
      rst_l = 1'b1;
      push_ev(base + 1, ACT, 1'b0, 3'd3, 15'h0055, 1'b0, 1'b0, 1'b0);
      push_ev(base + 4, RD,  1'b0, 3'd3, 15'h0011, 1'b1, 1'b0, 1'b0);
      wait_ack("s6_after_rst");

      repeat (5) @(negedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
